// File: rtl/bus_interface_unit.sv
// Bus interface unit: turns core RD/WR level requests into timed SRAM/ROM accesses
// with programmable wait states and external ready. Optional timeout: `BUS_TIMEOUT_EN.
module bus_interface_unit #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] abus_i,
  input  logic [15:0] dbus_out_i,
  output logic [15:0] dbus_in_o,
  input  logic        rd_i,
  input  logic        wr_i,
  output logic        ready_o,
  output logic        bus_err_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_dout_o,
  input  logic [15:0] mem_din_i,
  output logic        mem_ce_o,
  output logic        mem_oe_o,
  output logic        mem_we_o,
  input  logic        mem_rdy_i
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : gen_param_check
    $error("bus_interface_unit: WAIT_STATES or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        armed_q, armed_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] din_q, din_d;
`ifdef BUS_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      armed_q <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      din_q   <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      armed_q <= armed_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      din_q   <= din_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    armed_d = armed_q;
    write_d = write_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    din_d   = din_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (armed_q && (rd_i || wr_i)) begin
          write_d = wr_i;
          addr_d  = abus_i;
          dout_d  = dbus_out_i;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wait_d  = 4'(WAIT_STATES);
`ifdef BUS_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = 1'b0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (mem_rdy_i) begin
          if (!write_q) din_d = mem_din_i;
          state_d = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        // Count the cycles spent waiting on MEM_RDY; the TIMEOUT-th one gives up.
        else if (tmo_q == 16'(TIMEOUT - 1)) begin
          if (!write_q) din_d = 16'hFFFF;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      DONE: begin
        armed_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A dropped request re-arms, even in the DONE cycle itself.
    if (!rd_i && !wr_i) armed_d = 1'b1;
  end

  assign dbus_in_o  = din_q;
  assign mem_addr_o = addr_q;
  assign mem_dout_o = dout_q;
  assign mem_ce_o   = (state_q == SETUP) || (state_q == ACCESS);
  assign mem_oe_o   = (state_q == ACCESS) && !write_q;
  assign mem_we_o   = (state_q == ACCESS) && write_q;
  assign ready_o    = (state_q == DONE);
`ifdef BUS_TIMEOUT_EN
  assign bus_err_o  = (state_q == DONE) && err_q;
`else
  assign bus_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit: table of single accesses plus hand-written
// sequences for held requests, mid-access reset and (with BUS_TIMEOUT_EN) timeout.
module tb_bus_interface_unit;

  localparam int WaitStates = 1;
  localparam int Timeout    = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] abus_i, dbus_out_i, dbus_in_o;
  logic        rd_i, wr_i, ready_o, bus_err_o;
  logic [15:0] mem_addr_o, mem_dout_o, mem_din_i;
  logic        mem_ce_o, mem_oe_o, mem_we_o, mem_rdy_i;

  int checksRun    = 0;
  int checksPassed = 0;

  bus_interface_unit #(.WAIT_STATES(WaitStates), .TIMEOUT(Timeout)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .abus_i(abus_i), .dbus_out_i(dbus_out_i),
    .dbus_in_o(dbus_in_o), .rd_i(rd_i), .wr_i(wr_i), .ready_o(ready_o),
    .bus_err_o(bus_err_o), .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o),
    .mem_din_i(mem_din_i), .mem_ce_o(mem_ce_o), .mem_oe_o(mem_oe_o),
    .mem_we_o(mem_we_o), .mem_rdy_i(mem_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] abus;
    logic [15:0] dout;
    logic [15:0] din;
    int          low;
    int          expLat;
    int          expOe;
    int          expWe;
    logic [15:0] expDbus;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksRun++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one access starting just after a rising edge; returns what was observed.
  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] din, input int lowCycles,
                               output int latency, output int oeCnt, output int weCnt,
                               output logic [15:0] addrSeen, output logic [15:0] doutSeen,
                               output logic errSeen, output int unstable, output logic readyAfter);
    int exitCycle;
    exitCycle = 2 + WaitStates + lowCycles;
    latency = -1; oeCnt = 0; weCnt = 0; unstable = 0;
    addrSeen = '0; doutSeen = '0; errSeen = 1'b0; readyAfter = 1'b1;
    rd_i = r; wr_i = w; abus_i = a; dbus_out_i = d;
    for (int cyc = 0; cyc < 40; cyc++) begin
      mem_rdy_i = !(cyc >= 2 + WaitStates && cyc < exitCycle);
      mem_din_i = (cyc == exitCycle) ? din : 16'h0BAD;
      if (cyc > 0) begin
        abus_i = ~a;
        dbus_out_i = ~d;
      end
      @(negedge clk_i);
      if (mem_oe_o) oeCnt++;
      if (mem_we_o) weCnt++;
      if ((mem_ce_o || ready_o) && (mem_addr_o !== a || mem_dout_o !== d)) unstable++;
      if (ready_o) begin
        latency = cyc; addrSeen = mem_addr_o; doutSeen = mem_dout_o; errSeen = bus_err_o;
        break;
      end
      nextCycle();
    end
    nextCycle();
    rd_i = 1'b0; wr_i = 1'b0; mem_rdy_i = 1'b1;
    @(negedge clk_i);
    readyAfter = ready_o;
    nextCycle();
  endtask

  initial begin
    int lat, oeC, weC, unst, readyCnt, ceCnt;
    logic [15:0] addrS, doutS;
    logic errS, rdyA;

    vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0, 4, 2, 0, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h0040, 16'hA5A5, 16'h1111, 0, 4, 0, 2, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h1357, 3, 7, 5, 0, 16'h1357};
    vecs[3] = '{1'b1, 1'b1, 16'h8000, 16'h5A5A, 16'h2468, 0, 4, 0, 2, 16'h1357};
    vecs[4] = '{1'b0, 1'b1, 16'h7FFF, 16'h0F0F, 16'h9999, 2, 6, 0, 4, 16'h1357};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFE, 16'hC3C3, 16'h0001, 1, 5, 3, 0, 16'h0001};

    reset_i = 1'b1; rd_i = 1'b0; wr_i = 1'b0; abus_i = '0; dbus_out_i = '0;
    mem_din_i = '0; mem_rdy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset dbus_in", dbus_in_o, 16'h0000);
    checkOutput("reset ready", ready_o, 1'b0);
    checkOutput("reset bus_err", bus_err_o, 1'b0);
    checkOutput("reset mem_addr", mem_addr_o, 16'h0000);
    checkOutput("reset mem_dout", mem_dout_o, 16'h0000);
    checkOutput("reset ce/oe/we", {mem_ce_o, mem_oe_o, mem_we_o}, 3'b000);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    nextCycle();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].abus, vecs[i].dout, vecs[i].din, vecs[i].low,
                    lat, oeC, weC, addrS, doutS, errS, unst, rdyA);
      $display("[TB] vector %0d: latency %0d", i, lat);
      checkOutput($sformatf("v%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d oe cycles", i), oeC, vecs[i].expOe);
      checkOutput($sformatf("v%0d we cycles", i), weC, vecs[i].expWe);
      checkOutput($sformatf("v%0d mem_addr", i), addrS, vecs[i].abus);
      checkOutput($sformatf("v%0d mem_dout", i), doutS, vecs[i].dout);
      checkOutput($sformatf("v%0d bus_err", i), errS, 1'b0);
      checkOutput($sformatf("v%0d addr/dout stable", i), unst, 0);
      checkOutput($sformatf("v%0d ready one-cycle", i), rdyA, 1'b0);
      checkOutput($sformatf("v%0d dbus_in", i), dbus_in_o, vecs[i].expDbus);
    end

    // Held read request: one access only, then a re-raise after one low cycle.
    rd_i = 1'b1; abus_i = 16'h2222; mem_din_i = 16'h7777; mem_rdy_i = 1'b1;
    readyCnt = 0; ceCnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk_i);
      if (ready_o) readyCnt++;
      if (mem_ce_o) ceCnt++;
      nextCycle();
    end
    checkOutput("held rd ready pulses", readyCnt, 1);
    checkOutput("held rd ce cycles", ceCnt, 3);
    checkOutput("held rd dbus_in", dbus_in_o, 16'h7777);
    rd_i = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'h2468, 16'h0000, 16'hABCD, 0, lat, oeC, weC, addrS, doutS, errS, unst, rdyA);
    checkOutput("rearm latency", lat, 4);
    checkOutput("rearm dbus_in", dbus_in_o, 16'hABCD);

    // Reset while in ACCESS abandons the access.
    rd_i = 1'b1; abus_i = 16'h3333; mem_din_i = 16'h4444; mem_rdy_i = 1'b1;
    nextCycle();
    nextCycle();
    reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("pre-reset oe", mem_oe_o, 1'b1);
    nextCycle();
    reset_i = 1'b0; rd_i = 1'b0;
    @(negedge clk_i);
    checkOutput("mid reset ce/oe/we", {mem_ce_o, mem_oe_o, mem_we_o}, 3'b000);
    checkOutput("mid reset dbus_in", dbus_in_o, 16'h0000);
    checkOutput("mid reset mem_addr", mem_addr_o, 16'h0000);
    readyCnt = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (ready_o) readyCnt++;
      @(negedge clk_i);
    end
    checkOutput("mid reset no ready", readyCnt, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'h5555, 16'h0000, 16'h6666, 0, lat, oeC, weC, addrS, doutS, errS, unst, rdyA);
    checkOutput("post reset latency", lat, 4);
    checkOutput("post reset dbus_in", dbus_in_o, 16'h6666);

`ifdef BUS_TIMEOUT_EN
    applyStimulus(1'b1, 1'b0, 16'h0A0A, 16'h0000, 16'hDDDD, 1000, lat, oeC, weC, addrS, doutS, errS, unst, rdyA);
    checkOutput("timeout latency", lat, 7);
    checkOutput("timeout bus_err", errS, 1'b1);
    checkOutput("timeout dbus_in", dbus_in_o, 16'hFFFF);
    checkOutput("timeout back idle", {mem_ce_o, ready_o, bus_err_o}, 3'b000);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
